// File: rtl/quant_block_scheduler.sv
// -----------------------------------------------------------------------------
// quant_block_scheduler
//
// Takes one 8x8 block of Q16.16 DCT coefficients at a time, multiplies every
// coefficient by the matching entry of the luma or chroma inverse quantization
// table through a bank of LANES fixed_multiplier instances (LANES coefficients
// per clock), and hands the assembled block downstream. One block in flight.
//
// Optional build macro: QUANT_ROUND_EN
//   defined   -> each lane result is rounded half away from zero to an integer
//                Q16.16 value before it is stored.
//   undefined -> the truncated Q16.16 product is stored unchanged.
//
// Parameters:
//   LANES          multipliers instantiated (1,2,4,8,16,32,64)
//   SUBSAMPLE_420  0: component order Y,Cb,Cr   1: Y,Y,Y,Y,Cb,Cr
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input block handshake
//   in_sof            restart component sequence (sampled with handshake)
//   in_block          64 x 32-bit coefficients, coefficient i at [32*i +: 32]
//   out_valid/out_ready output block handshake
//   out_block         64 x 32-bit quantized coefficients, same packing
//   out_is_luma       luma table used for this block
//   out_comp          0=Y, 1=Cb, 2=Cr
//   busy              block being processed or waiting to be taken
// -----------------------------------------------------------------------------

// Signed Q16.16 x Q16.16 multiply, result shifted back to Q16.16 and truncated.
module fixed_multiplier (
  input  logic signed [31:0] a_i,
  input  logic signed [31:0] b_i,
  output logic        [31:0] p_o
);
  logic signed [63:0] a_ext_s;
  logic signed [63:0] b_ext_s;
  logic signed [63:0] prod_s;

  assign a_ext_s = a_i;
  assign b_ext_s = b_i;
  assign prod_s  = a_ext_s * b_ext_s;
  assign p_o     = 32'(prod_s >>> 16);
endmodule

module quant_block_scheduler #(
  parameter int LANES         = 8,
  parameter int SUBSAMPLE_420 = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sof,
  input  logic [2047:0] in_block,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2047:0] out_block,
  output logic          out_is_luma,
  output logic [1:0]    out_comp,
  output logic          busy
);

  localparam int BEATS  = 64 / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam int PERIOD = (SUBSAMPLE_420 != 0) ? 6 : 3;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 ||
          LANES == 16 || LANES == 32 || LANES == 64)) begin : g_bad_lanes
      $error("quant_block_scheduler: LANES must be 1,2,4,8,16,32 or 64");
    end
  endgenerate

  // Standard JPEG quantization tables, row-major, entry 0 written first.
  localparam logic [511:0] LUMA_Q = {
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };
  localparam logic [511:0] CHROMA_Q = {
    8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
  };

  // Inverse table in Q16.16: floor(1.0 / q), packed like the coefficient block.
  function automatic logic [2047:0] inv_table(input logic [511:0] q);
    logic [2047:0] t;
    t = '0;
    for (int i = 0; i < 64; i++) begin
      t[32*i +: 32] = 32'd65536 / {24'd0, q[8*(63-i) +: 8]};
    end
    return t;
  endfunction

  localparam logic [2047:0] luma_qtable_inv   = inv_table(LUMA_Q);
  localparam logic [2047:0] chroma_qtable_inv = inv_table(CHROMA_Q);

  // Round half away from zero to an integer Q16.16 value.
  function automatic logic [31:0] round_half_away(input logic [31:0] v);
    logic [31:0] mag;
    mag = v[31] ? (32'd0 - v) : v;
    mag = (mag + 32'h0000_8000) & 32'hFFFF_0000;
    return v[31] ? (32'd0 - mag) : mag;
  endfunction

  // Component for a sequence position.
  function automatic logic [1:0] comp_of(input logic [2:0] pos);
    logic [1:0] c;
    if (SUBSAMPLE_420 != 0) begin
      if (pos < 3'd4)       c = 2'd0;
      else if (pos == 3'd4) c = 2'd1;
      else                  c = 2'd2;
    end else begin
      c = pos[1:0];
    end
    return c;
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [2:0]        pos_q, pos_d;
  logic [1:0]        comp_q, comp_d;
  logic              is_luma_q, is_luma_d;
  logic [2047:0]     in_buf_q, in_buf_d;
  logic [2047:0]     out_buf_q, out_buf_d;

  logic [2:0]  pos_used_s;
  logic [1:0]  comp_new_s;
  logic [31:0] lane_a_s [LANES];
  logic [31:0] lane_b_s [LANES];
  logic [31:0] lane_p_s [LANES];
  logic [31:0] lane_r_s [LANES];

  // Operand selection: lane j works on coefficient beat*LANES + j.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_a_s[j] = in_buf_q[32*(int'(beat_q)*LANES + j) +: 32];
      if (is_luma_q) begin
        lane_b_s[j] = luma_qtable_inv[32*(int'(beat_q)*LANES + j) +: 32];
      end else begin
        lane_b_s[j] = chroma_qtable_inv[32*(int'(beat_q)*LANES + j) +: 32];
      end
    end
  end

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      fixed_multiplier u_mul (
        .a_i (lane_a_s[g]),
        .b_i (lane_b_s[g]),
        .p_o (lane_p_s[g])
      );
`ifdef QUANT_ROUND_EN
      assign lane_r_s[g] = round_half_away(lane_p_s[g]);
`else
      assign lane_r_s[g] = lane_p_s[g];
`endif
    end
  endgenerate

  // An in_sof handshake restarts the component sequence at position 0.
  assign pos_used_s = in_sof ? 3'd0 : pos_q;
  assign comp_new_s = comp_of(pos_used_s);

  // Next-state logic for the FSM and all datapath registers.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    pos_d     = pos_q;
    comp_d    = comp_q;
    is_luma_d = is_luma_q;
    in_buf_d  = in_buf_q;
    out_buf_d = out_buf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_buf_d  = in_block;
          comp_d    = comp_new_s;
          is_luma_d = (comp_new_s == 2'd0);
          pos_d     = (pos_used_s == 3'(PERIOD - 1)) ? 3'd0 : pos_used_s + 3'd1;
          beat_d    = '0;
          state_d   = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int j = 0; j < LANES; j++) begin
          out_buf_d[32*(int'(beat_q)*LANES + j) +: 32] = lane_r_s[j];
        end
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = DONE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      pos_q     <= 3'd0;
      comp_q    <= 2'd0;
      is_luma_q <= 1'b0;
      in_buf_q  <= '0;
      out_buf_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      pos_q     <= pos_d;
      comp_q    <= comp_d;
      is_luma_q <= is_luma_d;
      in_buf_q  <= in_buf_d;
      out_buf_q <= out_buf_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign out_block   = out_buf_q;
  assign out_comp    = comp_q;
  assign out_is_luma = is_luma_q;

endmodule

// File: tb/tb_quant_block_scheduler.sv
module tb_quant_block_scheduler;

  localparam int LANES = 8;
  localparam int LAT   = 64 / LANES + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sof;
  logic [2047:0] in_block;
  logic          out_ready;

  // DUT 0: SUBSAMPLE_420=0, DUT 1: SUBSAMPLE_420=1, driven in lockstep.
  logic          in_ready0, out_valid0, out_is_luma0, busy0;
  logic [2047:0] out_block0;
  logic [1:0]    out_comp0;
  logic          in_ready1, out_valid1, out_is_luma1, busy1;
  logic [2047:0] out_block1;
  logic [1:0]    out_comp1;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int            pos0, pos1;
  int            exp_comp0, exp_comp1;
  logic [2047:0] exp_blk0, exp_blk1;

  int luma_q [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};
  int chroma_q [64] = '{
    17, 18, 24, 47, 99, 99, 99, 99,   18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,   47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99};

  quant_block_scheduler #(.LANES(LANES), .SUBSAMPLE_420(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_sof(in_sof),
    .in_block(in_block), .out_valid(out_valid0), .out_ready(out_ready),
    .out_block(out_block0), .out_is_luma(out_is_luma0), .out_comp(out_comp0), .busy(busy0));

  quant_block_scheduler #(.LANES(LANES), .SUBSAMPLE_420(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_sof(in_sof),
    .in_block(in_block), .out_valid(out_valid1), .out_ready(out_ready),
    .out_block(out_block1), .out_is_luma(out_is_luma1), .out_comp(out_comp1), .busy(busy1));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [2047:0] obs, input logic [2047:0] expv);
    int k;
    k = 0;
    for (int i = 63; i >= 0; i--) begin
      if (obs[32*i +: 32] !== expv[32*i +: 32]) k = i;
    end
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s word %0d observed=%h expected=%h", tag, k, obs[32*k +: 32], expv[32*k +: 32]);
    end
  endtask

  // Quantized coefficient: Q16.16 product with floor(65536/q), >>>16, 32-bit wrap.
  function automatic logic [31:0] model_coef(input logic [31:0] c, input int q);
    longint signed a, p;
    logic [63:0]   pr;
    logic [31:0]   t, mag;
    a  = longint'($signed(c));
    p  = (a * longint'(65536 / q)) >>> 16;
    pr = p;
    t  = pr[31:0];
`ifdef QUANT_ROUND_EN
    mag = t[31] ? (32'd0 - t) : t;
    mag = (mag + 32'h0000_8000) & 32'hFFFF_0000;
    t   = t[31] ? (32'd0 - mag) : mag;
`endif
    return t;
  endfunction

  function automatic logic [2047:0] model_block(input logic [2047:0] blk, input int comp);
    logic [2047:0] r;
    for (int i = 0; i < 64; i++) begin
      r[32*i +: 32] = model_coef(blk[32*i +: 32], (comp == 0) ? luma_q[i] : chroma_q[i]);
    end
    return r;
  endfunction

  function automatic int comp_of(input int pos, input bit s420);
    if (s420) return (pos < 4) ? 0 : ((pos == 4) ? 1 : 2);
    return pos;
  endfunction

  function automatic logic [2047:0] rand_block();
    logic [2047:0] b;
    for (int i = 0; i < 64; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy0"}, 32'(in_ready0), 32'd1);
    chk({tag, "_vld0"}, 32'(out_valid0), 32'd0);
    chk_blk({tag, "_blk0"}, out_block0, 2048'd0);
    chk({tag, "_luma0"}, 32'(out_is_luma0), 32'd0);
    chk({tag, "_comp0"}, 32'(out_comp0), 32'd0);
    chk({tag, "_busy0"}, 32'(busy0), 32'd0);
    chk({tag, "_rdy1"}, 32'(in_ready1), 32'd1);
    chk({tag, "_vld1"}, 32'(out_valid1), 32'd0);
    chk_blk({tag, "_blk1"}, out_block1, 2048'd0);
    chk({tag, "_busy1"}, 32'(busy1), 32'd0);
  endtask

  // Present a block for one cycle (DUTs must be ready) and update the model.
  task automatic do_accept(input logic [2047:0] blk, input bit sof);
    int u;
    in_block = blk;
    in_sof   = sof;
    in_valid = 1'b1;
    chk("acc_rdy0", 32'(in_ready0), 32'd1);
    chk("acc_rdy1", 32'(in_ready1), 32'd1);
    step();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    u = sof ? 0 : pos0;
    exp_comp0 = comp_of(u, 1'b0);
    pos0 = (u + 1) % 3;
    exp_blk0 = model_block(blk, exp_comp0);
    u = sof ? 0 : pos1;
    exp_comp1 = comp_of(u, 1'b1);
    pos1 = (u + 1) % 6;
    exp_blk1 = model_block(blk, exp_comp1);
    chk("run_busy0", 32'(busy0), 32'd1);
    chk("run_rdy0", 32'(in_ready0), 32'd0);
  endtask

  // Wait (bounded) for out_valid, check latency and the delivered block.
  task automatic wait_out();
    int cnt;
    cnt = 1;
    while (out_valid0 !== 1'b1 && cnt < 64) begin
      in_sof   = 1'($urandom_range(0, 1));
      in_block = rand_block();
      step();
      cnt++;
    end
    in_sof = 1'b0;
    chk("latency", 32'(cnt), 32'(LAT));
    chk("vld1", 32'(out_valid1), 32'd1);
    chk_blk("blk0", out_block0, exp_blk0);
    chk_blk("blk1", out_block1, exp_blk1);
    chk("comp0", 32'(out_comp0), 32'(exp_comp0));
    chk("comp1", 32'(out_comp1), 32'(exp_comp1));
    chk("luma0", 32'(out_is_luma0), 32'(exp_comp0 == 0));
    chk("luma1", 32'(out_is_luma1), 32'(exp_comp1 == 0));
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    step();
    chk("post_vld0", 32'(out_valid0), 32'd0);
    chk("post_rdy0", 32'(in_ready0), 32'd1);
    chk("post_busy0", 32'(busy0), 32'd0);
  endtask

  initial begin
    logic [2047:0] b, e;
    int exp3 [3]   = '{0, 1, 2};
    int exp420 [8] = '{0, 0, 0, 0, 1, 2, 0, 0};

    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_block = '0; out_ready = 1'b1;
    pos0 = 0; pos1 = 0;
    step(); step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Single luma block: 16.0 * (1/16) = 1.0
    b = '0; b[31:0] = 32'h0010_0000;
    do_accept(b, 1'b1);
    wait_out();
    e = '0; e[31:0] = 32'h0001_0000;
    chk_blk("one_blk", out_block0, e);
    chk("one_comp", 32'(out_comp0), 32'd0);
    chk("one_luma", 32'(out_is_luma0), 32'd1);
    finish_out();

    // Y,Cb,Cr with 17.0 in coefficient 0
    b = '0; b[31:0] = 32'h0011_0000;
    for (int n = 0; n < 3; n++) begin
      do_accept(b, n == 0);
      wait_out();
      chk("ycc_comp", 32'(out_comp0), 32'(exp3[n]));
      if (n == 1) begin
`ifdef QUANT_ROUND_EN
        chk("cb_coef0", out_block0[31:0], 32'h0001_0000);
`else
        chk("cb_coef0", out_block0[31:0], 32'h0000_FFFF);
`endif
      end
      finish_out();
    end

    // 4:2:0 order on dut1, sof on first and eighth block only
    for (int n = 0; n < 8; n++) begin
      do_accept(rand_block(), (n == 0) || (n == 7));
      wait_out();
      chk("s420_comp", 32'(out_comp1), 32'(exp420[n]));
      finish_out();
    end

    // Output back-pressure with a second block waiting
    out_ready = 1'b0;
    do_accept(rand_block(), 1'b0);
    wait_out();
    b = rand_block();
    in_block = b; in_valid = 1'b1; in_sof = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      chk("stall_vld", 32'(out_valid0), 32'd1);
      chk("stall_rdy", 32'(in_ready0), 32'd0);
      chk_blk("stall_blk", out_block0, exp_blk0);
    end
    out_ready = 1'b1;
    step();
    chk("rel_rdy", 32'(in_ready0), 32'd1);
    chk("rel_vld", 32'(out_valid0), 32'd0);
    do_accept(b, 1'b0);
    wait_out();
    finish_out();

    // Reset on beat 3 of RUN: block dropped, sequence restarts
    do_accept(rand_block(), 1'b0);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    pos0 = 0; pos1 = 0;
    chk_reset_outputs("midrst");
    for (int n = 0; n < 12; n++) begin
      step();
      chk("drop_vld0", 32'(out_valid0), 32'd0);
      chk("drop_vld1", 32'(out_valid1), 32'd0);
    end
    do_accept(rand_block(), 1'b0);
    wait_out();
    chk("rst_seq_comp", 32'(out_comp0), 32'd0);
    finish_out();

    // Negative coefficients on luma entry 0
    b = '0; b[31:0] = 32'hFFF0_0000;
    do_accept(b, 1'b1);
    wait_out();
    chk("neg16", out_block0[31:0], 32'hFFFF_0000);
    finish_out();
    b = '0; b[31:0] = 32'hFFF8_0000;
    do_accept(b, 1'b1);
    wait_out();
`ifdef QUANT_ROUND_EN
    chk("neg_half", out_block0[31:0], 32'hFFFF_0000);
`else
    chk("neg_half", out_block0[31:0], 32'hFFFF_8000);
`endif
    finish_out();

    // Random blocks and random sof
    for (int n = 0; n < 8; n++) begin
      do_accept(rand_block(), $urandom_range(0, 3) == 0);
      wait_out();
      finish_out();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
